// File: rtl/dvs_event_fifo_param.sv
// dvs_event_fifo_param: first-word-fall-through event FIFO for DVS event words.
// Supports any DEPTH (including non-power-of-two) and an optional overwrite
// mode that evicts the oldest entry on push-when-full.
// Optional statistics (overflow_cnt, hwm, clr_stats) are compiled in only when
// the macro DVS_FIFO_STATS_EN is defined; otherwise those outputs read zero.
module dvs_event_fifo_param #(
    parameter int EVENT_W   = 32,
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 0,
    parameter int AF_LEVEL  = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [EVENT_W-1:0]         in_event,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EVENT_W-1:0]         out_event,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    input  logic                       clr_stats,
    output logic [15:0]                overflow_cnt,
    output logic [$clog2(DEPTH+1)-1:0] hwm
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [EVENT_W-1:0] mem [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count_next;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               evict;

    // Pointers wrap by explicit compare so any DEPTH works.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign out_valid   = !empty;
    assign out_event   = mem[rd_ptr];
    assign in_ready    = (OVERWRITE != 0) ? 1'b1 : !full;
    assign almost_full = (count >= CW'(AF_LEVEL));

    assign push  = in_valid && in_ready;
    assign pop   = out_valid && out_ready;
    // Only reachable in overwrite mode: a push into a full FIFO that is not
    // also being popped drops the oldest entry by advancing the read pointer.
    assign evict = push && full && !pop;

    // Next occupancy: push-only grows, pop-only shrinks, push+pop or evict holds.
    always_comb begin
        count_next = count;
        if (push && !pop && !full) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    // Event storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_event;
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop || evict) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

`ifdef DVS_FIFO_STATS_EN
    logic [15:0]   ovf_q;
    logic [CW-1:0] hwm_q;

    // Saturating count of events refused or evicted while full; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else if (clr_stats) begin
            ovf_q <= '0;
        end else if (in_valid && full && !pop && (ovf_q != 16'hFFFF)) begin
            ovf_q <= ovf_q + 16'd1;
        end
    end

    // High-water mark of occupancy; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_q <= '0;
        end else if (clr_stats) begin
            hwm_q <= '0;
        end else if (count_next > hwm_q) begin
            hwm_q <= count_next;
        end
    end

    assign overflow_cnt = ovf_q;
    assign hwm          = hwm_q;
`else
    logic stats_unused;

    assign overflow_cnt = '0;
    assign hwm          = '0;
    assign stats_unused = clr_stats;
`endif

endmodule

// File: tb/tb_dvs_event_fifo_param.sv
// tb_dvs_event_fifo_param: three FIFO configurations driven by a shared
// stimulus stream and checked every cycle against a queue-based model.
module tb_dvs_event_fifo_param;

`ifdef DVS_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_event;
    logic       out_ready;
    logic       clr_stats;

    logic        in_ready    [3];
    logic        out_valid   [3];
    logic [7:0]  out_event   [3];
    logic [2:0]  count       [3];
    logic        almost_full [3];
    logic [15:0] ovf         [3];
    logic [2:0]  hwm         [3];

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: one queue plus statistics per configuration.
    logic [7:0]  mq [3][$];
    int unsigned mdepth [3];
    int unsigned mow    [3];
    int unsigned maf    [3];
    int unsigned movf   [3];
    int unsigned mhwm   [3];

    always #5 clk = ~clk;

    dvs_event_fifo_param #(.EVENT_W(8), .DEPTH(5), .OVERWRITE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_event(in_event), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_event(out_event[0]), .count(count[0]), .almost_full(almost_full[0]),
        .clr_stats(clr_stats), .overflow_cnt(ovf[0]), .hwm(hwm[0])
    );

    dvs_event_fifo_param #(.EVENT_W(8), .DEPTH(4), .OVERWRITE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_event(in_event), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_event(out_event[1]), .count(count[1]), .almost_full(almost_full[1]),
        .clr_stats(clr_stats), .overflow_cnt(ovf[1]), .hwm(hwm[1])
    );

    dvs_event_fifo_param #(.EVENT_W(8), .DEPTH(4), .OVERWRITE(0), .AF_LEVEL(3)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_event(in_event), .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_event(out_event[2]), .count(count[2]), .almost_full(almost_full[2]),
        .clr_stats(clr_stats), .overflow_cnt(ovf[2]), .hwm(hwm[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every DUT output with the model's current state.
    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            int unsigned sz;
            sz = mq[k].size();
            chk($sformatf("count%0d", k), 32'(count[k]), sz);
            chk($sformatf("out_valid%0d", k), 32'(out_valid[k]), 32'(sz != 0));
            chk($sformatf("in_ready%0d", k), 32'(in_ready[k]), 32'((mow[k] != 0) || (sz != mdepth[k])));
            chk($sformatf("almost_full%0d", k), 32'(almost_full[k]), 32'(sz >= maf[k]));
            chk($sformatf("ovf%0d", k), 32'(ovf[k]), STATS ? movf[k] : 0);
            chk($sformatf("hwm%0d", k), 32'(hwm[k]), STATS ? mhwm[k] : 0);
            if (sz != 0) begin
                chk($sformatf("head%0d", k), 32'(out_event[k]), 32'(mq[k][0]));
            end
        end
    endtask

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int unsigned sz;
            bit full, pop, push, ovf_inc;
            sz      = mq[k].size();
            full    = (sz == mdepth[k]);
            pop     = (sz != 0) && out_ready;
            push    = in_valid && ((mow[k] != 0) || !full);
            ovf_inc = in_valid && full && !pop;
            if (pop) void'(mq[k].pop_front());
            if (push) begin
                if (mq[k].size() == mdepth[k]) void'(mq[k].pop_front());
                mq[k].push_back(in_event);
            end
            if (clr_stats) begin
                movf[k] = 0;
                mhwm[k] = 0;
            end else begin
                if (ovf_inc && movf[k] != 32'hFFFF) movf[k]++;
                if (mq[k].size() > mhwm[k]) mhwm[k] = mq[k].size();
            end
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            movf[k] = 0;
            mhwm[k] = 0;
        end
    endtask

    // One cycle: check state, apply inputs, confirm no same-cycle effect, step model.
    task automatic tick(input logic iv, input logic [7:0] e, input logic ordy, input logic clr);
        @(negedge clk);
        check_all();
        in_valid  = iv;
        in_event  = e;
        out_ready = ordy;
        clr_stats = clr;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("nobypass%0d", k), 32'(out_valid[k]), 32'(mq[k].size() != 0));
            chk($sformatf("ready_comb%0d", k), 32'(in_ready[k]),
                32'((mow[k] != 0) || (mq[k].size() != mdepth[k])));
        end
        model_step();
    endtask

    task automatic idle();
        tick(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        mdepth = '{5, 4, 4};
        mow    = '{0, 1, 0};
        maf    = '{3, 2, 3};
        model_clear();
        rst_n = 1'b0; in_valid = 1'b0; in_event = '0; out_ready = 1'b0; clr_stats = 1'b0;
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill past capacity with no pops.
        for (int i = 1; i <= 6; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
        idle();
        chk("a_count_full", 32'(count[0]), 5);
        chk("a_ready_full", 32'(in_ready[0]), 0);
        chk("a_ovf", 32'(ovf[0]), STATS ? 1 : 0);
        chk("b_count_full", 32'(count[1]), 4);
        chk("b_ovf", 32'(ovf[1]), STATS ? 2 : 0);
        chk("c_af_full", 32'(almost_full[2]), 1);
        chk("c_hwm_full", 32'(hwm[2]), STATS ? 4 : 0);

        // Clear statistics while full.
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        idle();
        chk("c_hwm_clr", 32'(hwm[2]), 0);
        chk("a_ovf_clr", 32'(ovf[0]), 0);

        // Drain and confirm ordering.
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            if (i < 5) chk("a_order", 32'(out_event[0]), 32'(i + 1));
            if (i < 4) chk("b_order", 32'(out_event[1]), 32'(i + 3));
        end
        idle();
        chk("a_empty", 32'(out_valid[0]), 0);

        // Steady push+pop at occupancy 2 across pointer wrap.
        tick(1'b1, 8'h10, 1'b0, 1'b0);
        tick(1'b1, 8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) tick(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
        idle();
        chk("a_count_stream", 32'(count[0]), 2);
        chk("a_head_stream", 32'(out_event[0]), 32'h2A);

        // Asynchronous reset with three entries queued.
        tick(1'b1, 8'h33, 1'b0, 1'b0);
        idle();
        chk("a_count_pre_rst", 32'(count[0]), 3);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_count%0d", k), 32'(count[k]), 0);
            chk($sformatf("rst_valid%0d", k), 32'(out_valid[k]), 0);
            chk($sformatf("rst_ready%0d", k), 32'(in_ready[k]), 1);
            chk($sformatf("rst_af%0d", k), 32'(almost_full[k]), 0);
            chk($sformatf("rst_ovf%0d", k), 32'(ovf[k]), 0);
            chk($sformatf("rst_hwm%0d", k), 32'(hwm[k]), 0);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, 8'hA5, 1'b0, 1'b0);
        idle();
        chk("a_after_rst", 32'(out_event[0]), 32'hA5);
        chk("a_valid_after_rst", 32'(out_valid[0]), 1);

        // Randomized traffic with push-heavy, balanced and pop-heavy phases.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 150; i++) begin
                tick(1'($urandom_range(0, 99) < (70 - 20 * ph)),
                     8'($urandom),
                     1'($urandom_range(0, 99) < (30 + 20 * ph)),
                     1'($urandom_range(0, 99) < 3));
            end
        end
        idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
